// File: rtl/packet_arbiter.sv
// Packet-granular round-robin arbiter: merges two byte streams into one
// tagged stream, holding the grant for a whole packet.
module packet_arbiter #(
    parameter int unsigned TAG_ENABLE = 1
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       valid0,
    input  logic [7:0] data0,
    input  logic       last0,
    output logic       ready0,
    input  logic       valid1,
    input  logic [7:0] data1,
    input  logic       last1,
    output logic       ready1,
    output logic       valid,
    output logic [7:0] data,
    output logic       last,
    input  logic       ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        BODY   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_grant;
    logic       w_grant_nxt;
    logic       r_prio;
    logic       w_prio_nxt;

    logic       r_valid;
    logic [7:0] r_data;
    logic       r_last;

    logic       w_load_ok;
    logic       w_load;
    logic [7:0] w_load_data;
    logic       w_load_last;

    logic       w_src_valid;
    logic [7:0] w_src_data;
    logic       w_src_last;

    assign w_load_ok   = !r_valid | ready;

    // Only the granted source is ever observed.
    assign w_src_valid = r_grant ? valid1 : valid0;
    assign w_src_data  = r_grant ? data1  : data0;
    assign w_src_last  = r_grant ? last1  : last0;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_prio_nxt  = r_prio;
        w_load      = 1'b0;
        w_load_data = 8'h00;
        w_load_last = 1'b0;
        ready0      = 1'b0;
        ready1      = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid0 | valid1) begin
                    if (valid0 & valid1) begin
                        w_grant_nxt = r_prio;
                    end else begin
                        w_grant_nxt = valid1;
                    end
                    w_state_nxt = (TAG_ENABLE != 0) ? HEADER : BODY;
                end
            end
            HEADER: begin
                if (w_load_ok) begin
                    w_load      = 1'b1;
                    w_load_data = {7'b0, r_grant};
                    w_state_nxt = BODY;
                end
            end
            BODY: begin
                // Ready follows downstream space only, never valid_i.
                ready0 = !r_grant & w_load_ok;
                ready1 = r_grant & w_load_ok;
                if (w_src_valid & w_load_ok) begin
                    w_load      = 1'b1;
                    w_load_data = w_src_data;
                    w_load_last = w_src_last;
                    if (w_src_last) begin
                        w_state_nxt = IDLE;
                        w_prio_nxt  = ~r_grant;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_load_data;
            r_last  <= w_load_last;
        end else if (r_valid & ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;
    assign last  = r_last;

endmodule
